// File: rtl/dispatch4x2.sv
// Round-robin fan-out dispatcher: one valid/ready input stream spread over four
// registered output lanes in strict order 0,1,2,3, with an all-lane broadcast mode.
module dispatch4x2 #(
    parameter int WIDTH = 2
) (
    input  logic             CLK,
    input  logic             ASYNCRESET,
    input  logic [WIDTH-1:0] I,
    input  logic             I_valid,
    output logic             I_ready,
    input  logic             BCAST,
    output logic [WIDTH-1:0] O0,
    output logic [WIDTH-1:0] O1,
    output logic [WIDTH-1:0] O2,
    output logic [WIDTH-1:0] O3,
    output logic [3:0]       O_valid,
    input  logic [3:0]       O_ready,
    output logic [1:0]       PTR
);

    logic [3:0]       r_full;
    logic [1:0]       r_ptr;
    logic [WIDTH-1:0] r_data [4];

    logic [3:0]       w_free;
    logic [3:0]       w_load;
    logic [3:0]       w_full_nxt;
    logic             w_ready;
    logic             w_accept;

    // Lane availability, accept decision and per-lane load/occupancy next state
    always_comb begin
        // a full lane draining this cycle can take a new word without a bubble
        w_free = ~r_full | O_ready;
        if (BCAST) begin
            w_ready = &w_free;
        end else begin
            w_ready = w_free[r_ptr];
        end
        w_accept = I_valid & w_ready;
        w_load   = 4'b0000;
        if (w_accept) begin
            if (BCAST) begin
                w_load = 4'b1111;
            end else begin
                w_load = 4'b0001 << r_ptr;
            end
        end else begin
            w_load = 4'b0000;
        end
        w_full_nxt = w_load | (r_full & ~O_ready);
    end

    // Lane registers and round-robin pointer
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            r_full <= 4'b0000;
            r_ptr  <= 2'd0;
            for (int k = 0; k < 4; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            r_full <= w_full_nxt;
            // broadcast leaves the rotation where it was
            if (w_accept && !BCAST) begin
                r_ptr <= r_ptr + 2'd1;
            end
            for (int k = 0; k < 4; k++) begin
                if (w_load[k]) begin
                    r_data[k] <= I;
                end
            end
        end
    end

    assign I_ready = w_ready;
    assign O_valid = r_full;
    assign PTR     = r_ptr;
    assign O0      = r_data[0];
    assign O1      = r_data[1];
    assign O2      = r_data[2];
    assign O3      = r_data[3];

endmodule

// File: tb/tb_dispatch4x2.sv
// Directed table-driven bench for dispatch4x2 (WIDTH=2) plus hand-written reset sequences.
module tb_dispatch4x2;

    logic       CLK;
    logic       ASYNCRESET;
    logic [1:0] I;
    logic       I_valid;
    logic       I_ready;
    logic       BCAST;
    logic [1:0] O0, O1, O2, O3;
    logic [3:0] O_valid;
    logic [3:0] O_ready;
    logic [1:0] PTR;

    int total;
    int bad;

    dispatch4x2 #(.WIDTH(2)) dut (
        .CLK(CLK), .ASYNCRESET(ASYNCRESET), .I(I), .I_valid(I_valid), .I_ready(I_ready),
        .BCAST(BCAST), .O0(O0), .O1(O1), .O2(O2), .O3(O3),
        .O_valid(O_valid), .O_ready(O_ready), .PTR(PTR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct packed {
        logic       bc;
        logic       v;
        logic [1:0] i;
        logic [3:0] ordy;
        logic       rdy;
        logic [3:0] ov;
        logic [1:0] ptr;
        logic [7:0] d;
    } vec_t;

    vec_t tbl [30];

    function automatic vec_t mk(input logic bc, input logic v, input logic [1:0] i,
                                input logic [3:0] ordy, input logic rdy, input logic [3:0] ov,
                                input logic [1:0] ptr, input logic [1:0] d3, input logic [1:0] d2,
                                input logic [1:0] d1, input logic [1:0] d0);
        vec_t r;
        r.bc = bc; r.v = v; r.i = i; r.ordy = ordy; r.rdy = rdy;
        r.ov = ov; r.ptr = ptr; r.d = {d3, d2, d1, d0};
        return r;
    endfunction

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic step(input logic bc, input logic v, input logic [1:0] i, input logic [3:0] ordy);
        @(negedge CLK);
        BCAST = bc; I_valid = v; I = i; O_ready = ordy;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_lanes(input string name, input logic [3:0] ov, input logic [7:0] d);
        logic [7:0] o_all;
        o_all = {O3, O2, O1, O0};
        chk({name, " O_valid"}, int'(O_valid), int'(ov));
        for (int k = 0; k < 4; k++) begin
            if (ov[k]) begin
                chk($sformatf("%s O%0d", name, k), int'(o_all[2*k +: 2]), int'(d[2*k +: 2]));
            end
        end
    endtask

    initial begin
        total = 0; bad = 0;
        ASYNCRESET = 1'b1; I = 2'd0; I_valid = 1'b0; BCAST = 1'b0; O_ready = 4'b0000;

        // round robin
        tbl[0]  = mk(1'b0, 1'b1, 2'd1, 4'b1111, 1'b1, 4'b0001, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1);
        tbl[1]  = mk(1'b0, 1'b1, 2'd2, 4'b1111, 1'b1, 4'b0010, 2'd2, 2'd0, 2'd0, 2'd2, 2'd0);
        tbl[2]  = mk(1'b0, 1'b1, 2'd3, 4'b1111, 1'b1, 4'b0100, 2'd3, 2'd0, 2'd3, 2'd0, 2'd0);
        tbl[3]  = mk(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        tbl[4]  = mk(1'b0, 1'b1, 2'd1, 4'b1111, 1'b1, 4'b0001, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1);
        tbl[5]  = mk(1'b0, 1'b0, 2'd0, 4'b1111, 1'b1, 4'b0000, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0);
        tbl[6]  = mk(1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0);
        tbl[7]  = mk(1'b0, 1'b1, 2'd2, 4'b1111, 1'b1, 4'b0010, 2'd2, 2'd0, 2'd0, 2'd2, 2'd0);
        tbl[8]  = mk(1'b0, 1'b1, 2'd3, 4'b1111, 1'b1, 4'b0100, 2'd3, 2'd0, 2'd3, 2'd0, 2'd0);
        tbl[9]  = mk(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        tbl[10] = mk(1'b0, 1'b0, 2'd0, 4'b1111, 1'b1, 4'b0000, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        // backpressure on lane 0, then drain+load of lane 0
        tbl[11] = mk(1'b0, 1'b1, 2'd1, 4'b1110, 1'b1, 4'b0001, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1);
        tbl[12] = mk(1'b0, 1'b1, 2'd2, 4'b1110, 1'b1, 4'b0011, 2'd2, 2'd0, 2'd0, 2'd2, 2'd1);
        tbl[13] = mk(1'b0, 1'b1, 2'd3, 4'b1110, 1'b1, 4'b0101, 2'd3, 2'd0, 2'd3, 2'd0, 2'd1);
        tbl[14] = mk(1'b0, 1'b1, 2'd0, 4'b1110, 1'b1, 4'b1001, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1);
        tbl[15] = mk(1'b0, 1'b1, 2'd2, 4'b1110, 1'b0, 4'b0001, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1);
        tbl[16] = mk(1'b0, 1'b1, 2'd2, 4'b1111, 1'b1, 4'b0001, 2'd1, 2'd0, 2'd0, 2'd0, 2'd2);
        // fill all lanes, then drain+load lane 1
        tbl[17] = mk(1'b0, 1'b1, 2'd3, 4'b1111, 1'b1, 4'b0010, 2'd2, 2'd0, 2'd0, 2'd3, 2'd0);
        tbl[18] = mk(1'b0, 1'b1, 2'd1, 4'b0000, 1'b1, 4'b0110, 2'd3, 2'd0, 2'd1, 2'd3, 2'd0);
        tbl[19] = mk(1'b0, 1'b1, 2'd2, 4'b0000, 1'b1, 4'b1110, 2'd0, 2'd2, 2'd1, 2'd3, 2'd0);
        tbl[20] = mk(1'b0, 1'b1, 2'd3, 4'b0000, 1'b1, 4'b1111, 2'd1, 2'd2, 2'd1, 2'd3, 2'd3);
        tbl[21] = mk(1'b0, 1'b1, 2'd0, 4'b0010, 1'b1, 4'b1111, 2'd2, 2'd2, 2'd1, 2'd0, 2'd3);
        // broadcast waits on lane 2, free lanes stay empty
        tbl[22] = mk(1'b1, 1'b1, 2'd2, 4'b1011, 1'b0, 4'b0100, 2'd2, 2'd0, 2'd1, 2'd0, 2'd0);
        tbl[23] = mk(1'b1, 1'b1, 2'd2, 4'b1011, 1'b0, 4'b0100, 2'd2, 2'd0, 2'd1, 2'd0, 2'd0);
        tbl[24] = mk(1'b1, 1'b1, 2'd2, 4'b0100, 1'b1, 4'b1111, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2);
        tbl[25] = mk(1'b0, 1'b0, 2'd0, 4'b1111, 1'b1, 4'b0000, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0);
        // I_ready follows BCAST without I_valid; pointer wrap 3 -> 0
        tbl[26] = mk(1'b0, 1'b1, 2'd1, 4'b1111, 1'b1, 4'b0100, 2'd3, 2'd0, 2'd1, 2'd0, 2'd0);
        tbl[27] = mk(1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0100, 2'd3, 2'd0, 2'd1, 2'd0, 2'd0);
        tbl[28] = mk(1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 4'b0100, 2'd3, 2'd0, 2'd1, 2'd0, 2'd0);
        tbl[29] = mk(1'b0, 1'b1, 2'd3, 4'b0000, 1'b1, 4'b1100, 2'd0, 2'd3, 2'd1, 2'd0, 2'd0);

        #2;
        chk("rst O_valid", int'(O_valid), 0);
        chk("rst PTR", int'(PTR), 0);
        chk("rst I_ready", int'(I_ready), 1);
        chk("rst O", int'({O3, O2, O1, O0}), 0);
        @(negedge CLK);
        ASYNCRESET = 1'b0;

        for (int n = 0; n < 30; n++) begin
            @(negedge CLK);
            BCAST = tbl[n].bc; I_valid = tbl[n].v; I = tbl[n].i; O_ready = tbl[n].ordy;
            #1;
            chk($sformatf("vec%0d I_ready", n), int'(I_ready), int'(tbl[n].rdy));
            @(posedge CLK);
            #1;
            chk($sformatf("vec%0d PTR", n), int'(PTR), int'(tbl[n].ptr));
            chk_lanes($sformatf("vec%0d", n), tbl[n].ov, tbl[n].d);
        end

        // async reset between edges clears lanes immediately
        @(negedge CLK);
        I_valid = 1'b0; BCAST = 1'b0; O_ready = 4'b0000;
        #2 ASYNCRESET = 1'b1;
        #1;
        chk("areset O_valid", int'(O_valid), 0);
        chk("areset O", int'({O3, O2, O1, O0}), 0);
        chk("areset I_ready", int'(I_ready), 1);
        @(negedge CLK);
        ASYNCRESET = 1'b0;

        // build O_valid=0101 with PTR=2
        step(1'b0, 1'b1, 2'd1, 4'b1111);
        step(1'b0, 1'b1, 2'd2, 4'b1111);
        step(1'b0, 1'b0, 2'd0, 4'b1111);
        step(1'b0, 1'b1, 2'd1, 4'b0000);
        step(1'b0, 1'b1, 2'd2, 4'b0000);
        step(1'b0, 1'b1, 2'd3, 4'b0000);
        step(1'b0, 1'b1, 2'd1, 4'b0000);
        chk_lanes("fill4", 4'b1111, {2'd2, 2'd1, 2'd1, 2'd3});
        chk("fill4 PTR", int'(PTR), 2);
        step(1'b0, 1'b0, 2'd0, 4'b1010);
        chk_lanes("pre-reset", 4'b0101, {2'd0, 2'd1, 2'd0, 2'd3});
        chk("pre-reset PTR", int'(PTR), 2);

        // mid-stream reset held across an edge with a word offered
        @(negedge CLK);
        O_ready = 4'b0000; I_valid = 1'b1; I = 2'd3;
        #2 ASYNCRESET = 1'b1;
        #1;
        chk("midrst O_valid", int'(O_valid), 0);
        chk("midrst PTR", int'(PTR), 0);
        @(posedge CLK);
        #1;
        chk("midrst hold O_valid", int'(O_valid), 0);
        @(negedge CLK);
        ASYNCRESET = 1'b0; I_valid = 1'b0;
        step(1'b0, 1'b1, 2'd2, 4'b0000);
        chk_lanes("post-reset", 4'b0001, {2'd0, 2'd0, 2'd0, 2'd2});
        chk("post-reset PTR", int'(PTR), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dispatch4x2.md
# dispatch4x2

Round-robin fan-out dispatcher: accepts a single stream of WIDTH-bit words on a valid/ready input and distributes them across four registered output lanes, each with its own valid/ready handshake. It is the splitting counterpart to the 4-input, 2-bit lane-merging reducers in the mantle library. It sits where one producer feeds four parallel consumers. An optional broadcast mode copies one word to all four lanes at once.

## Interface
- WIDTH, 2, data width of the input word and of each output lane
- CLK  input  1  clock, rising-edge
- ASYNCRESET  input  1  asynchronous, active-high reset
- I  input  WIDTH  input data word
- I_valid  input  1  input word present
- I_ready  output  1  dispatcher accepts I this cycle (combinational)
- BCAST  input  1  sampled with I_valid; 1 = copy word to all four lanes
- O0, O1, O2, O3  output  WIDTH  lane data registers
- O_valid  output  4  bit k = lane k holds a word
- O_ready  input  4  bit k = consumer k takes lane k's word this cycle
- PTR  output  2  current round-robin target lane (status)

## Operation
- State: per-lane full flag and data register; 2-bit round-robin pointer ptr.
- Lane k is "free" when it is empty, or when it is full and O_ready[k]=1 (drained this cycle).
- Unicast (BCAST=0): I_ready = free(ptr). On I_valid & I_ready: lane ptr loads I, full[ptr] is set, ptr advances to (ptr+1) mod 4.
- Broadcast (BCAST=1): I_ready = free(0) & free(1) & free(2) & free(3). On accept, all four lanes load I and set full. ptr is unchanged.
- The dispatcher never skips a busy lane. Strict order 0,1,2,3,0,... so consumers see words in the sequence the producer sent them.
- Lane drain: O_valid[k] & O_ready[k] with no new load clears full[k]. The data register holds its last value and is don't-care while empty.
- Simultaneous drain and load on the same lane in the same cycle: the lane stays full with the new word, so throughput is one word per cycle per lane.
- I_ready does not depend on I_valid. It depends on BCAST, ptr, full[] and O_ready only.
- O_valid[k] = full[k]. The O/O_valid outputs change only on CLK edges or reset.

## Timing
- Reset (ASYNCRESET=1, takes effect immediately with no clock needed): full = 0000, O_valid = 0000, O0..O3 = 0, ptr = PTR = 0. I_ready reads 1 during and after reset.
- Latency: a word accepted at edge n appears on its lane's O/O_valid right after edge n (1 cycle).
- Throughput: one input word per cycle as long as the target lane(s) are free.
- Reset asserted mid-stream: all in-flight lane words are discarded and ptr returns to 0. No word is accepted while ASYNCRESET=1.
- Pointer wrap: 3 -> 0 on accept at ptr=3.
- Full condition: if the target lane is full and not draining, I_ready=0 and the input stalls. Other lanes keep draining independently.
- Empty: O_valid=0000 with no input causes no state change.
- A broadcast request waits until all four lanes are free in the same cycle, and lanes that are already free stay empty while it waits. A unicast request issued while BCAST is toggling is judged purely on the BCAST value in that cycle.

## Test plan
- Reset: assert ASYNCRESET between edges → O_valid=0000, PTR=0, O0..O3=0 immediately. I_ready=1 after release.
- Round-robin with WIDTH=2, O_ready=1111, BCAST=0: stream 1,2,3,0,1 on consecutive cycles → lanes 0,1,2,3,0 receive 1,2,3,0,1, each one cycle after acceptance. PTR sequence is 0,1,2,3,0,1.
- Backpressure: O_ready=1110, send 5 words → words 1-4 fill lanes 0-3, and the 5th stalls with I_ready=0 at ptr=0. Raise O_ready[0] → the 5th word is accepted in that same cycle and lane 0 shows it next cycle.
- Broadcast: all lanes empty, BCAST=1, I=2'b10 → all O=2'b10, O_valid=1111 next cycle, PTR unchanged. With lane 2 full and O_ready[2]=0, a second broadcast holds I_ready=0 until O_ready[2]=1.
- Simultaneous drain/load: lane 1 full with O_ready[1]=1 while a unicast targets lane 1 → O_valid[1] stays 1 and O1 updates to the new word with no bubble.
- Mid-stream reset: assert ASYNCRESET with O_valid=0101 and PTR=2 → O_valid=0000 and PTR=0. The next accepted word goes to lane 0.
